// File: rtl/data_memory_stream.sv
// data_memory_stream: ASIP data memory with a random-access port
// and a burst read engine streaming a contiguous range over valid/ready.
module data_memory_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Memory_write,
  input  logic [ADDR_WIDTH-1:0] Address_in,
  input  logic [DATA_WIDTH-1:0] Data_in,
  output logic [DATA_WIDTH-1:0] Data_out,
  input  logic                  Burst_start,
  input  logic [ADDR_WIDTH-1:0] Burst_addr,
  input  logic [ADDR_WIDTH:0]   Burst_len,
  output logic                  Burst_busy,
  output logic                  Stream_valid,
  input  logic                  Stream_ready,
  output logic [DATA_WIDTH-1:0] Stream_data,
  output logic                  Stream_last,
  output logic                  Burst_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] sdata_q, sdata_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;

  // Storage array: no reset, contents survive RST
  always_ff @(posedge CLK) begin
    if (Memory_write) begin
      mem_q[Address_in] <= Data_in;
    end
  end

  // Random-access read, read-before-write on same address
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[Address_in];
    end
  end

  // Burst engine registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      sdata_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      sdata_q <= sdata_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Burst next state: load a word whenever the output slot is free
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    sdata_d = sdata_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Burst_start) begin
          if (Burst_len != LEN_ZERO) begin
            sdata_d = mem_q[Burst_addr];
            valid_d = 1'b1;
            last_d  = (Burst_len == LEN_ONE);
            ptr_d   = Burst_addr + PTR_ONE;
            rem_d   = Burst_len - LEN_ONE;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!valid_q || Stream_ready) begin
          if (rem_q != LEN_ZERO) begin
            sdata_d = mem_q[ptr_q];
            valid_d = 1'b1;
            last_d  = (rem_q == LEN_ONE);
            ptr_d   = ptr_q + PTR_ONE;
            rem_d   = rem_q - LEN_ONE;
          end else begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Data_out     = rdata_q;
  assign Burst_busy   = (state_q == RUN);
  assign Stream_valid = valid_q;
  assign Stream_data  = sdata_q;
  assign Stream_last  = last_q;
  assign Burst_done   = done_q;

endmodule

// File: tb/tb_data_memory_stream.sv
// tb_data_memory_stream: directed self-checking bench
// for the random port and the burst stream engine.
`timescale 1ns/1ps
module tb_data_memory_stream;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Memory_write;
  logic [7:0] Address_in;
  logic [7:0] Data_in;
  logic [7:0] Data_out;
  logic       Burst_start;
  logic [7:0] Burst_addr;
  logic [8:0] Burst_len;
  logic       Burst_busy;
  logic       Stream_valid;
  logic       Stream_ready;
  logic [7:0] Stream_data;
  logic       Stream_last;
  logic       Burst_done;

  int checks = 0;
  int failures = 0;

  data_memory_stream #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .Memory_write(Memory_write), .Address_in(Address_in),
    .Data_in(Data_in), .Data_out(Data_out),
    .Burst_start(Burst_start), .Burst_addr(Burst_addr),
    .Burst_len(Burst_len), .Burst_busy(Burst_busy),
    .Stream_valid(Stream_valid), .Stream_ready(Stream_ready),
    .Stream_data(Stream_data), .Stream_last(Stream_last),
    .Burst_done(Burst_done)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    Memory_write = 1'b1;
    Address_in = a;
    Data_in = d;
    tick();
    Memory_write = 1'b0;
  endtask

  task automatic start(input logic [7:0] a, input logic [8:0] n);
    Burst_start = 1'b1;
    Burst_addr = a;
    Burst_len = n;
    tick();
    Burst_start = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({Data_out, Stream_data} !== 16'h0 ||
        {Stream_valid, Stream_last, Burst_busy, Burst_done} !== 4'b0) begin
      failures++;
      $display("FAIL reset: dout=%h sdata=%h v/l/b/d=%b%b%b%b want all 0",
               Data_out, Stream_data, Stream_valid, Stream_last,
               Burst_busy, Burst_done);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_random_port();
    for (int k = 0; k < 8; k++) wr(8'(k), 8'h10 + 8'(k));
    for (int k = 0; k < 8; k++) begin
      Address_in = 8'(k);
      tick();
      checks++;
      if (Data_out !== 8'h10 + 8'(k)) begin
        failures++;
        $display("FAIL read[%0d]: got %h want %h", k, Data_out, 8'h10 + 8'(k));
      end
    end
    wr(8'd3, 8'h99);
    checks++;
    if (Data_out !== 8'h13) begin
      failures++;
      $display("FAIL rbw: got %h want 13", Data_out);
    end
    tick();
    checks++;
    if (Data_out !== 8'h99) begin
      failures++;
      $display("FAIL rbw_new: got %h want 99", Data_out);
    end
    wr(8'd3, 8'h13);
  endtask

  task automatic test_burst_ready();
    Stream_ready = 1'b1;
    start(8'd2, 9'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!Stream_valid || !Burst_busy || Stream_data !== 8'h12 + 8'(i) ||
          Stream_last !== (i == 3) || Burst_done) begin
        failures++;
        $display("FAIL burst_word%0d: v=%b b=%b d=%h l=%b dn=%b want 1 1 %h %b 0",
                 i, Stream_valid, Burst_busy, Stream_data, Stream_last,
                 Burst_done, 8'h12 + 8'(i), (i == 3));
      end
      tick();
    end
    checks++;
    if (Burst_done !== 1'b1 || Burst_busy !== 1'b0 || Stream_valid !== 1'b0) begin
      failures++;
      $display("FAIL burst_done: dn=%b b=%b v=%b want 1 0 0",
               Burst_done, Burst_busy, Stream_valid);
    end
    tick();
    checks++;
    if (Burst_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse: dn=%b want 0", Burst_done);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    int idx;
    pat = 8'b1011_1001;
    idx = 0;
    Stream_ready = 1'b1;
    start(8'd2, 9'd4);
    for (int c = 0; c < 40 && idx < 4; c++) begin
      Stream_ready = pat[c % 8];
      checks++;
      if (!Stream_valid || Stream_data !== 8'h12 + 8'(idx) ||
          Stream_last !== (idx == 3)) begin
        failures++;
        $display("FAIL bp_c%0d: v=%b d=%h l=%b want 1 %h %b",
                 c, Stream_valid, Stream_data, Stream_last,
                 8'h12 + 8'(idx), (idx == 3));
      end
      if (Stream_ready) idx++;
      tick();
    end
    checks++;
    if (idx != 4 || Burst_done !== 1'b1 || Stream_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_done: words=%0d dn=%b v=%b want 4 1 0",
               idx, Burst_done, Stream_valid);
    end
    Stream_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] exp [4];
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wr(8'd254, 8'hAA);
    wr(8'd255, 8'hBB);
    wr(8'd0, 8'hCC);
    wr(8'd1, 8'hDD);
    Stream_ready = 1'b1;
    start(8'd254, 9'd4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!Stream_valid || Stream_data !== exp[i] ||
          Stream_last !== (i == 3)) begin
        failures++;
        $display("FAIL wrap%0d: v=%b d=%h l=%b want 1 %h %b",
                 i, Stream_valid, Stream_data, Stream_last, exp[i], (i == 3));
      end
      tick();
    end
    checks++;
    if (Burst_done !== 1'b1) begin
      failures++;
      $display("FAIL wrap_done: dn=%b want 1", Burst_done);
    end
    tick();
  endtask

  task automatic test_len0_and_ignore();
    start(8'd5, 9'd0);
    checks++;
    if (Burst_done !== 1'b1 || Stream_valid !== 1'b0 || Burst_busy !== 1'b0) begin
      failures++;
      $display("FAIL len0: dn=%b v=%b b=%b want 1 0 0",
               Burst_done, Stream_valid, Burst_busy);
    end
    tick();
    checks++;
    if (Burst_done !== 1'b0 || Stream_valid !== 1'b0) begin
      failures++;
      $display("FAIL len0_after: dn=%b v=%b want 0 0", Burst_done, Stream_valid);
    end
    Stream_ready = 1'b0;
    start(8'd2, 9'd4);
    start(8'd0, 9'd2);
    Stream_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!Stream_valid || Stream_data !== 8'h12 + 8'(i) ||
          Stream_last !== (i == 3)) begin
        failures++;
        $display("FAIL ignore%0d: v=%b d=%h l=%b want 1 %h %b",
                 i, Stream_valid, Stream_data, Stream_last,
                 8'h12 + 8'(i), (i == 3));
      end
      tick();
    end
    checks++;
    if (Burst_done !== 1'b1) begin
      failures++;
      $display("FAIL ignore_done: dn=%b want 1", Burst_done);
    end
    tick();
    checks++;
    if (Stream_valid !== 1'b0 || Burst_busy !== 1'b0) begin
      failures++;
      $display("FAIL ignore_idle: v=%b b=%b want 0 0", Stream_valid, Burst_busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    Stream_ready = 1'b1;
    start(8'd10, 9'd6);
    wr(8'd3, 8'h13);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (Stream_valid || Burst_busy || Burst_done || Stream_last ||
        Stream_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid: v=%b b=%b dn=%b l=%b d=%h want 0 0 0 0 00",
               Stream_valid, Burst_busy, Burst_done, Stream_last, Stream_data);
    end
    tick();
    checks++;
    if (Burst_done !== 1'b0 || Stream_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_nodone: dn=%b v=%b want 0 0", Burst_done, Stream_valid);
    end
    start(8'd3, 9'd2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!Stream_valid || Stream_data !== 8'h13 + 8'(i) ||
          Stream_last !== (i == 1)) begin
        failures++;
        $display("FAIL post_rst%0d: v=%b d=%h l=%b want 1 %h %b",
                 i, Stream_valid, Stream_data, Stream_last,
                 8'h13 + 8'(i), (i == 1));
      end
      tick();
    end
    checks++;
    if (Burst_done !== 1'b1) begin
      failures++;
      $display("FAIL post_rst_done: dn=%b want 1", Burst_done);
    end
    Address_in = 8'd6;
    tick();
    checks++;
    if (Data_out !== 8'h16) begin
      failures++;
      $display("FAIL mem_intact: got %h want 16", Data_out);
    end
  endtask

  initial begin
    RST = 1'b1;
    Memory_write = 1'b0;
    Address_in = '0;
    Data_in = '0;
    Burst_start = 1'b0;
    Burst_addr = '0;
    Burst_len = '0;
    Stream_ready = 1'b1;
    #2;
    test_reset();
    test_random_port();
    test_burst_ready();
    test_backpressure();
    test_wrap();
    test_len0_and_ignore();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
